// File: rtl/seg_scan_ctrl.sv
// Scan controller for common-anode 7-segment digits that share one 3-bit decoder.
// Optional SCAN_AUTOINC_EN: digit 0 code increments once per completed frame.
module seg_scan_ctrl #(
  parameter int NDIG = 4,
  parameter int DIV  = 50000,
  parameter int GAP  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            wr_en,
  input  logic [1:0]      wr_addr,
  input  logic [2:0]      wr_data,
  output logic [2:0]      dec_abc,
  output logic [NDIG-1:0] dig_an,
  output logic [1:0]      cur_dig,
  output logic            frame_done
);

  localparam int MAXC = (DIV > GAP) ? DIV : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
  localparam logic [1:0]    DIG_LAST = 2'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [1:0]      cur_q, cur_n;
  logic [NDIG-1:0] an_q, an_n;
  logic            fd_q, fd_n;
  logic [NDIG-1:0] lit_mask;
  logic [2:0]      codes [NDIG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      an_q    <= '1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      cur_q   <= cur_n;
      an_q    <= an_n;
      fd_q    <= fd_n;
    end
  end

  always_comb begin
    lit_mask = '1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      lit_mask[i] = (cur_q != 2'(i));
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    cur_n   = cur_q;
    an_n    = an_q;
    fd_n    = 1'b0;
    case (state_q)
      IDLE: begin
        an_n  = '1;
        cur_n = '0;
        cnt_n = '0;
        if (en) state_n = BLANK;
      end
      BLANK: begin
        if (!en) begin
          state_n = IDLE;
          cnt_n   = '0;
          cur_n   = '0;
          an_n    = '1;
        end else if (cnt_q == GAP_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
          an_n    = lit_mask;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      SHOW: begin
        // Dropping en discards the partial frame, so no frame_done here.
        if (!en) begin
          state_n = IDLE;
          cnt_n   = '0;
          cur_n   = '0;
          an_n    = '1;
        end else if (cnt_q == DIV_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
          an_n    = '1;
          cur_n   = (cur_q == DIG_LAST) ? 2'd0 : cur_q + 2'd1;
          fd_n    = (cur_q == DIG_LAST);
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        cur_n   = '0;
        an_n    = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        codes[i] <= '0;
      end
    end else begin
`ifdef SCAN_AUTOINC_EN
      if (fd_q) codes[0] <= codes[0] + 3'd1;
`endif
      // Writes come last so a same-cycle write to digit 0 beats the increment.
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (wr_en && wr_addr == 2'(i)) codes[i] <= wr_data;
      end
    end
  end

  always_comb begin
    dec_abc = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (cur_q == 2'(i)) dec_abc = codes[i];
    end
  end

  assign dig_an     = an_q;
  assign cur_dig    = cur_q;
  assign frame_done = fd_q;

endmodule
